// File: rtl/dmem_pkg.sv
// Shared defaults and the posted-write entry type for the data memory with
// write-back buffer.
package dmem_pkg;

  localparam int AW_DEF    = 7;
  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/dmem_wbuf_if.sv
// Write-back bus between the buffered data memory (master) and the backing
// store (slave).
interface dmem_wbuf_if
  import dmem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          bus_valid;
  logic          bus_ready;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_data;

  modport master (
    output bus_valid,
    output bus_addr,
    output bus_data,
    input  bus_ready
  );

  modport slave (
    input  bus_valid,
    input  bus_addr,
    input  bus_data,
    output bus_ready
  );

endinterface

// File: rtl/wb_fifo.sv
// Posted-write FIFO: power-of-two depth, one push and one pop per cycle,
// a push into a full FIFO is accepted only when a pop frees the slot.
module wb_fifo
  import dmem_pkg::*;
#(
  parameter int W     = AW_DEF + DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  ram_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Empty FIFO presents zeros so the bus is quiet after reset.
  assign dout  = empty ? '0 : ram_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) ram_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dmem_wbuf.sv
// Local data memory with a posted-write buffer that mirrors every write out
// to a backing store over a valid/ready bus.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            CEN,
  input  logic            WEN,
  input  logic            OEN,
  input  logic [AW-1:0]   A,
  input  logic [DW-1:0]   Data2Mem,
  output logic [DW-1:0]   ReadDataMem,
  dmem_wbuf_if.master     bus,
  output logic [CW-1:0]   wb_count,
  output logic            wb_full,
  output logic            overflow,
  input  logic            clr_ovf
);

  logic [DW-1:0]    mem_q [2**AW];
  logic             ovf_q, ovf_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             drop;
  logic [AW+DW-1:0] head;

  // Chip enable is not used to qualify accesses.
  logic unused_cen;
  assign unused_cen = CEN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
    end else if (!WEN) begin
      mem_q[A] <= Data2Mem;
    end
  end

  // Combinational read returns the pre-write word on a same-cycle write.
  assign ReadDataMem = OEN ? '0 : mem_q[A];

  assign pop  = !fifo_empty && bus.bus_ready;
  assign drop = !WEN && fifo_full && !pop;

  wb_fifo #(
    .W     (AW + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (!WEN),
    .pop   (pop),
    .din   ({A, Data2Mem}),
    .dout  (head),
    .count (wb_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.bus_valid = !fifo_empty;
  assign bus.bus_addr  = head[AW+DW-1:DW];
  assign bus.bus_data  = head[DW-1:0];
  assign wb_full       = fifo_full;

  // A new drop outranks a clear in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;

endmodule
